// File: rtl/onehot_enc_pkg.sv
// Shared types and helpers for the 4:2 one-hot encoder with debounce.
package onehot_enc_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DBNC    = 2'd1,
        PRESS   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot4(input logic [NUM_REQ-1:0] v);
        return (v != '0) && ((v & (v - NUM_REQ'(1))) == '0);
    endfunction

    // Strict encoder: only meaningful for one-hot input, anything else maps to 0.
    function automatic logic [1:0] enc_4t2(input logic [NUM_REQ-1:0] v);
        logic [1:0] code;
        case (v)
            4'b0001: code = 2'd0;
            4'b0010: code = 2'd1;
            4'b0100: code = 2'd2;
            4'b1000: code = 2'd3;
            default: code = 2'd0;
        endcase
        return code;
    endfunction

    // Priority encoder: highest set bit wins.
    function automatic logic [1:0] enc_4t2_prio(input logic [NUM_REQ-1:0] v);
        logic [1:0] code;
        if (v[3])      code = 2'd3;
        else if (v[2]) code = 2'd2;
        else if (v[1]) code = 2'd1;
        else           code = 2'd0;
        return code;
    endfunction

endpackage

// File: rtl/onehot_enc_4t2_dbnc_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/onehot_enc_4t2_dbnc.sv
// 4:2 one-hot encoder for board buttons: synchronise, debounce, validate,
// encode, and track press/release.
// Optional build macro ONEHOT_ENC_PRIORITY_EN: multi-hot samples are
// priority-encoded to their highest set bit instead of raising ERR.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request; waiting for a nonzero synchronised sample
// DBNC    | sample captured; counting consecutive matching samples
// PRESS   | press accepted (HELD=1); waiting for the input to change
// RELEASE | waiting for DB_CNT consecutive all-zero samples
module onehot_enc_4t2_dbnc
    import onehot_enc_pkg::*;
#(
    parameter int DB_CNT = 16,
    parameter int CNT_W  = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] D_IN,
    output logic [1:0]         SEL,
    output logic               VALID,
    output logic               HELD,
    output logic               ERR
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    logic [NUM_REQ-1:0] d_sync;
    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] samp, samp_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         sel_nxt;
    logic               valid_nxt, held_nxt, err_nxt;

    sync_2ff #(.W(NUM_REQ)) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (D_IN),
        .q   (d_sync)
    );

    // State, sample, counter and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            samp  <= '0;
            cnt   <= '0;
            SEL   <= '0;
            VALID <= 1'b0;
            HELD  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            state <= state_nxt;
            samp  <= samp_nxt;
            cnt   <= cnt_nxt;
            SEL   <= sel_nxt;
            VALID <= valid_nxt;
            HELD  <= held_nxt;
            ERR   <= err_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state;
        samp_nxt  = samp;
        cnt_nxt   = cnt;
        sel_nxt   = SEL;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (d_sync != '0) begin
                    samp_nxt  = d_sync;
                    cnt_nxt   = '0;
                    state_nxt = DBNC;
                end
            end

            DBNC: begin
                if (d_sync != samp) begin
                    // bounce: restart qualification from scratch
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (is_onehot4(samp)) begin
                        sel_nxt   = enc_4t2(samp);
                        valid_nxt = 1'b1;
                        state_nxt = PRESS;
                    end else begin
`ifdef ONEHOT_ENC_PRIORITY_EN
                        sel_nxt   = enc_4t2_prio(samp);
                        valid_nxt = 1'b1;
                        state_nxt = PRESS;
`else
                        err_nxt   = 1'b1;
                        state_nxt = RELEASE;
`endif
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            PRESS: begin
                if (d_sync != samp) begin
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end
            end

            RELEASE: begin
                if (d_sync != '0) begin
                    // any activity restarts the clean-release window
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase

        held_nxt = (state_nxt == PRESS);
    end

endmodule

// File: tb/tb_onehot_enc_4t2_dbnc.sv
// Bench for onehot_enc_4t2_dbnc: directed scenarios followed by random
// held patterns, all compared against a sample-history reference model.
module tb_onehot_enc_4t2_dbnc;

    localparam int DB = 4;
    localparam int CW = 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] D_IN;
    logic [1:0] SEL;
    logic       VALID, HELD, ERR;

    int n_vec = 0;
    int n_bad = 0;

    // reference model: sync pipeline, phase, run length, captured pattern
    logic [3:0] m_s1, m_s2, m_samp;
    int         m_phase;   // 0 waiting, 1 qualifying, 2 held, 3 releasing
    int         m_run;
    logic [1:0] m_sel;
    logic       m_valid, m_err, m_held;

    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int last_valid_cyc = -1;

    onehot_enc_4t2_dbnc #(.DB_CNT(DB), .CNT_W(CW)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .D_IN  (D_IN),
        .SEL   (SEL),
        .VALID (VALID),
        .HELD  (HELD),
        .ERR   (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    function automatic int popc(input logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 4; i++) if (v[i]) c++;
        return c;
    endfunction

    function automatic int hi_bit(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_samp = '0;
        m_phase = 0; m_run = 0;
        m_sel = '0; m_valid = 1'b0; m_err = 1'b0; m_held = 1'b0;
    endtask

    // One clock edge: decide on the synchronised sample, then shift in d.
    // A press is accepted after DB+1 identical nonzero samples starting from
    // the waiting phase; a release needs DB consecutive zero samples.
    task automatic model_edge(input logic [3:0] d);
        logic [3:0] ds;
        ds = m_s2;
        m_valid = 1'b0;
        m_err   = 1'b0;
        case (m_phase)
            0: if (ds != 0) begin m_samp = ds; m_run = 1; m_phase = 1; end
            1: begin
                if (ds != m_samp) m_phase = 0;
                else begin
                    m_run++;
                    if (m_run == DB + 1) begin
                        m_run = 0;
                        if (popc(m_samp) == 1) begin
                            m_valid = 1'b1; m_sel = 2'(hi_bit(m_samp)); m_phase = 2;
                        end else begin
`ifdef ONEHOT_ENC_PRIORITY_EN
                            m_valid = 1'b1; m_sel = 2'(hi_bit(m_samp)); m_phase = 2;
`else
                            m_err = 1'b1; m_phase = 3;
`endif
                        end
                    end
                end
            end
            2: if (ds != m_samp) begin m_phase = 3; m_run = 0; end
            default: begin
                if (ds == 0) begin
                    m_run++;
                    if (m_run == DB) m_phase = 0;
                end else m_run = 0;
            end
        endcase
        m_held = (m_phase == 2);
        m_s2 = m_s1;
        m_s1 = d;
    endtask

    task automatic apply(input logic [3:0] d);
        D_IN = d;
        model_edge(d);
        cyc++;
    endtask

    task automatic step(input logic [3:0] d);
        @(negedge CLK);
        check_val("sel",   32'(SEL),   32'(m_sel));
        check_val("valid", 32'(VALID), 32'(m_valid));
        check_val("held",  32'(HELD),  32'(m_held));
        check_val("err",   32'(ERR),   32'(m_err));
        if (VALID === 1'b1) begin valid_cnt++; last_valid_cyc = cyc; end
        if (ERR === 1'b1) err_cnt++;
        apply(d);
    endtask

    task automatic hold(input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) step(d);
    endtask

    initial begin
        int c0, v0, e0, len;
        logic [3:0] pat;

        RST  = 1'b1;
        D_IN = '0;
        model_reset();
        #12;
        check_val("rst_sel",   32'(SEL),   0);
        check_val("rst_valid", 32'(VALID), 0);
        check_val("rst_held",  32'(HELD),  0);
        check_val("rst_err",   32'(ERR),   0);
        @(negedge CLK);
        RST = 1'b0;
        apply(4'b0000);
        hold(4'b0000, 3);

        // clean press of code 2, latency and hold
        v0 = valid_cnt;
        c0 = cyc;
        hold(4'b0100, 12);
        check_val("t1_valid_once", 32'(valid_cnt - v0), 1);
        check_val("t1_latency",    32'(last_valid_cyc - c0), 32'(2 + 1 + DB));
        check_val("t1_sel",        32'(SEL), 2);
        check_val("t1_held",       32'(HELD), 1);
        hold(4'b0000, 8);
        check_val("t1_released",   32'(HELD), 0);

        // bouncing button, then stable
        v0 = valid_cnt;
        for (int i = 0; i < 20; i++) step(((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000);
        check_val("t2_no_valid_bounce", 32'(valid_cnt - v0), 0);
        hold(4'b0001, 12);
        check_val("t2_valid_once", 32'(valid_cnt - v0), 1);
        check_val("t2_sel",        32'(SEL), 0);
        hold(4'b0000, 8);

        // multi-hot sample
        v0 = valid_cnt;
        e0 = err_cnt;
        hold(4'b0110, 12);
`ifdef ONEHOT_ENC_PRIORITY_EN
        check_val("t3_valid", 32'(valid_cnt - v0), 1);
        check_val("t3_err",   32'(err_cnt - e0), 0);
        check_val("t3_sel",   32'(SEL), 2);
`else
        check_val("t3_valid", 32'(valid_cnt - v0), 0);
        check_val("t3_err",   32'(err_cnt - e0), 1);
        check_val("t3_sel",   32'(SEL), 0);
`endif
        hold(4'b0000, 8);

        // direct switch without a clean release
        v0 = valid_cnt;
        hold(4'b1000, 12);
        check_val("t4_sel3", 32'(SEL), 3);
        hold(4'b0010, 12);
        check_val("t4_no_second_valid", 32'(valid_cnt - v0), 1);
        check_val("t4_sel_kept",        32'(SEL), 3);
        hold(4'b0000, 8);
        hold(4'b0010, 12);
        check_val("t4_repress_valid", 32'(valid_cnt - v0), 2);
        check_val("t4_repress_sel",   32'(SEL), 1);
        hold(4'b0000, 8);

        // asynchronous reset mid-qualification with button held
        hold(4'b0010, 5);
        check_val("t5_model_qualifying", 32'(m_phase), 1);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check_val("t5_rst_sel",   32'(SEL),   0);
        check_val("t5_rst_valid", 32'(VALID), 0);
        check_val("t5_rst_held",  32'(HELD),  0);
        check_val("t5_rst_err",   32'(ERR),   0);
        model_reset();
        v0 = valid_cnt;
        e0 = err_cnt;
        @(negedge CLK);
        RST = 1'b0;
        apply(4'b0010);
        hold(4'b0010, 12);
        check_val("t5_valid_once", 32'(valid_cnt - v0), 1);
        check_val("t5_no_err",     32'(err_cnt - e0), 0);
        check_val("t5_sel",        32'(SEL), 1);
        hold(4'b0000, 8);

        // random held patterns
        for (int k = 0; k < 120; k++) begin
            case ($urandom_range(0, 3))
                0:       pat = 4'b0000;
                1, 2:    pat = 4'b0001 << $urandom_range(0, 3);
                default: pat = 4'($urandom_range(0, 15));
            endcase
            len = $urandom_range(1, 9);
            hold(pat, len);
        end
        hold(4'b0000, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
